axi_channel_arbiter: RTL and testbench
======================================

# axi_channel_arbiter

Packet-locked round-robin arbiter that time-shares one downstream beamforming weight/adder stage among the four ADC sample streams (channels 00, 01, 20, 21). Each stream carries 128-bit beats of sixteen 8-bit samples. The arbiter forwards whole packets (tlast-delimited) through one registered output slice and tags each beat with its source channel ID. It sits between the RF data converter capture streams and the shared weighting datapath.

## Interface
Parameters:
- DATA_WIDTH, 128, beat width of all streams (16 × 8-bit samples).
- TIMEOUT_CYCLES, 256, consecutive stall cycles before a granted packet is abandoned (used only with AXI_ARB_TIMEOUT_EN).

Ports:
- clock  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- ch_enable  in  4  per-channel enable; bit0=ch00, bit1=ch01, bit2=ch20, bit3=ch21.
- sXX_axis_tdata  in  DATA_WIDTH  input beat, XX ∈ {00,01,20,21}.
- sXX_axis_tvalid  in  1  input beat valid.
- sXX_axis_tlast  in  1  last beat of packet.
- sXX_axis_tready  out  1  input beat accepted when tvalid&tready.
- m_axis_tdata  out  DATA_WIDTH  output beat to weighting stage.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output last beat.
- m_axis_tid  out  2  source channel: 0=ch00, 1=ch01, 2=ch20, 3=ch21.
- m_axis_tready  in  1  downstream ready.
- timeout_err  out  1  one-cycle pulse on grant abandonment (tied 0 without macro).

## Operation
- States: IDLE, BUSY. Registers: grant[1:0], rr_ptr[1:0], output slice (tdata, tlast, tid, tvalid).
- IDLE: scan channels rr_ptr, rr_ptr+1, … mod 4; first with ch_enable=1 and tvalid=1 wins; grant<=winner, state<=BUSY. No candidate: stay IDLE.
- BUSY: only sXX_axis_tready of granted channel may be 1: tready = (grant==XX) & (state==BUSY) & (!m_axis_tvalid | m_axis_tready). All others 0.
- Beat accept (granted tvalid&tready): slice loads tdata, tlast, tid=grant; m_axis_tvalid<=1.
- Slice drains when m_axis_tvalid&m_axis_tready with no new accept: m_axis_tvalid<=0.
- Accept with tlast=1: state<=IDLE, rr_ptr<=grant+1 mod 4.
- ch_enable deasserted for granted channel mid-packet: packet completes; enable only gates new grants.
- Data passes unmodified; no width change.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, all sXX_axis_tready=0, timeout_err=0, state=IDLE, grant=0, rr_ptr=0.
- Arbitration: 1 cycle (IDLE), first beat accepted earliest next cycle.
- Latency: accepted beat visible on m_axis one cycle after acceptance.
- Throughput: 1 beat/cycle within a packet while m_axis_tready=1.
- Packet gap: 1 input-side idle cycle between packets (tlast accept → IDLE → BUSY).
- m_axis_tdata/tlast/tid stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous drain and accept: slice reloads, m_axis_tvalid stays 1.
- Reset mid-packet: all state cleared next edge; in-flight beat in slice discarded.
- All four requesting with rr_ptr=0: grant order 0,1,2,3,0.

## Configuration
- AXI_ARB_TIMEOUT_EN defined: stall counter counts consecutive BUSY cycles with granted tvalid=0; cleared on each accept and on entering BUSY. Reaching TIMEOUT_CYCLES: state<=IDLE, rr_ptr<=grant+1, timeout_err=1 for one cycle; no tlast synthesised, slice contents unaffected.
- Not defined: no counter; grant held indefinitely until tlast; timeout_err constant 0.

## Test plan
- Reset: assert reset 3 cycles with all tvalid=1 → all tready=0, m_axis_tvalid=0, tid=0 throughout; first grant to ch00 two cycles after release.
- Fairness: all four channels stream 4-beat packets, m_axis_tready=1 → tid sequence 0×4,1×4,2×4,3×4,0×4; one bubble between packets.
- Backpressure: ch01 sends beats 0xA1..0xA4, m_axis_tready toggles 1,0,0,1… → output data stable during stalls, order A1..A4, no loss/duplication, tlast only on A4.
- Enable gating: ch_enable=4'b1010, all valid → only tid 1 and 3 appear, alternating; ch_enable cleared for ch01 mid-packet → packet finishes, ch01 not re-granted.
- Reset mid-packet: reset asserted during beat 2 of 4 from ch20 → next cycle m_axis_tvalid=0, rr_ptr=0; restart grants ch00 first.
- Timeout (macro on, TIMEOUT_CYCLES=8): ch21 sends 1 beat without tlast then drops tvalid → timeout_err pulses exactly 8 stall cycles later, next grant to ch00; macro off → grant held, no pulse.

Source files
------------

// File: rtl/axi_channel_arbiter.sv
// axi_channel_arbiter
// Packet-locked round-robin arbiter that lets four ADC sample streams
// (ch00, ch01, ch20, ch21) share one downstream weighting stage. Whole
// tlast-delimited packets are forwarded through a single registered output
// slice. Each beat is tagged with its source channel on m_axis_tid.
//
// Optional feature: define AXI_ARB_TIMEOUT_EN to abandon a granted packet
// after TIMEOUT_CYCLES consecutive cycles without a valid beat from the
// granted source. When the macro is not defined, the grant is held until
// tlast arrives and timeout_err is tied low.

module axi_channel_arbiter #(
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            ch_enable,

  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,

  input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
  input  logic                  s01_axis_tvalid,
  input  logic                  s01_axis_tlast,
  output logic                  s01_axis_tready,

  input  logic [DATA_WIDTH-1:0] s20_axis_tdata,
  input  logic                  s20_axis_tvalid,
  input  logic                  s20_axis_tlast,
  output logic                  s20_axis_tready,

  input  logic [DATA_WIDTH-1:0] s21_axis_tdata,
  input  logic                  s21_axis_tvalid,
  input  logic                  s21_axis_tlast,
  output logic                  s21_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [1:0]            m_axis_tid,
  input  logic                  m_axis_tready,

  output logic                  timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  logic [1:0]            grant;
  logic [1:0]            rr_ptr;

  // Channel index order matches m_axis_tid: 0=ch00, 1=ch01, 2=ch20, 3=ch21.
  logic [3:0]            in_valid;
  logic [3:0]            in_last;
  logic [DATA_WIDTH-1:0] in_data [4];
  logic [3:0]            request;

  logic                  win_found;
  logic [1:0]            win_idx;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  slice_free;
  logic                  busy;
  logic                  accept;

  assign in_valid   = {s21_axis_tvalid, s20_axis_tvalid, s01_axis_tvalid, s00_axis_tvalid};
  assign in_last    = {s21_axis_tlast,  s20_axis_tlast,  s01_axis_tlast,  s00_axis_tlast};
  assign in_data[0] = s00_axis_tdata;
  assign in_data[1] = s01_axis_tdata;
  assign in_data[2] = s20_axis_tdata;
  assign in_data[3] = s21_axis_tdata;

  // Enable only gates new grants; a granted packet runs to completion.
  assign request = in_valid & ch_enable;

  // Round-robin search starting at rr_ptr; scanning offsets high to low lets
  // the smallest offset (closest to rr_ptr) win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (request[rr_ptr + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = rr_ptr + 2'(k);
      end
    end
  end

  assign sel_valid  = in_valid[grant];
  assign sel_last   = in_last[grant];
  assign sel_data   = in_data[grant];
  assign busy       = (state == BUSY);
  assign slice_free = !m_axis_tvalid || m_axis_tready;
  assign accept     = busy && sel_valid && slice_free;

  // Only the granted channel sees ready, and only when the slice can take a beat.
  assign s00_axis_tready = busy && slice_free && (grant == 2'd0);
  assign s01_axis_tready = busy && slice_free && (grant == 2'd1);
  assign s20_axis_tready = busy && slice_free && (grant == 2'd2);
  assign s21_axis_tready = busy && slice_free && (grant == 2'd3);

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;

  // Arbitration FSM, output slice and stall watchdog in one registered block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 2'd0;
      rr_ptr        <= 2'd0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= 2'd0;
      stall_cnt     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      timeout_err <= 1'b0;

      if (accept) begin
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last;
        m_axis_tid    <= grant;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (win_found) begin
            grant     <= win_idx;
            stall_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            stall_cnt <= '0;
            if (sel_last) begin
              state  <= IDLE;
              rr_ptr <= grant + 2'd1;
            end
          end else if (!sel_valid) begin
            // The slice is left alone on abandonment; no tlast is invented.
            if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
              stall_cnt   <= '0;
              state       <= IDLE;
              rr_ptr      <= grant + 2'd1;
              timeout_err <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;

  // Arbitration FSM and output slice in one registered block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 2'd0;
      rr_ptr        <= 2'd0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= 2'd0;
    end else begin
      if (accept) begin
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last;
        m_axis_tid    <= grant;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept && sel_last) begin
            state  <= IDLE;
            rr_ptr <= grant + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_axi_channel_arbiter.sv
// tb_axi_channel_arbiter
// Directed bench for axi_channel_arbiter. A small per-channel packet source
// feeds the four input streams; a monitor logs every output transfer, and
// each section compares against hand-computed beat sequences.
// Build with +define+AXI_ARB_TIMEOUT_EN to exercise the stall timeout.

module tb_axi_channel_arbiter;

  localparam int DW = 128;
  localparam int CW = DW + 8;

  logic          clock;
  logic          reset;
  logic [3:0]    ch_enable;
  logic [3:0]    tv;
  logic [3:0]    tl;
  logic [DW-1:0] td [4];
  logic          tr00, tr01, tr20, tr21;
  logic [3:0]    tr;

  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tid;
  logic          m_axis_tready;
  logic          timeout_err;

  int checks;
  int errors;

  // Source model state per channel
  int            pkts_left [4];
  int            pkt_len   [4];
  int            beat_idx  [4];
  int            seq_cnt   [4];
  logic [DW-1:0] base      [4];
  bit            hold      [4];
  bit            hold_after_hs [4];
  bit            drop_after_hs [4];
  logic [3:0]    hs;

  // Backpressure pattern 1,0,0,1 repeating
  bit            bp_mode;
  int            bp_i;
  logic [3:0]    bp_pat;

  // Monitor log of output transfers
  logic [1:0]    obs_tid  [$];
  logic          obs_last [$];
  logic [DW-1:0] obs_data [$];
  int            obs_cyc  [$];
  int            cyc;

  assign tr = {tr21, tr20, tr01, tr00};

  axi_channel_arbiter #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ch_enable       (ch_enable),
    .s00_axis_tdata  (td[0]),
    .s00_axis_tvalid (tv[0]),
    .s00_axis_tlast  (tl[0]),
    .s00_axis_tready (tr00),
    .s01_axis_tdata  (td[1]),
    .s01_axis_tvalid (tv[1]),
    .s01_axis_tlast  (tl[1]),
    .s01_axis_tready (tr01),
    .s20_axis_tdata  (td[2]),
    .s20_axis_tvalid (tv[2]),
    .s20_axis_tlast  (tl[2]),
    .s20_axis_tready (tr20),
    .s21_axis_tdata  (td[3]),
    .s21_axis_tvalid (tv[3]),
    .s21_axis_tlast  (tl[3]),
    .s21_axis_tready (tr21),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tid      (m_axis_tid),
    .m_axis_tready   (m_axis_tready),
    .timeout_err     (timeout_err)
  );

  // 100 MHz style free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [CW-1:0] observed,
                             input logic [CW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present the current beat of every source on its input stream
  task automatic driveSources();
    for (int i = 0; i < 4; i++) begin
      tv[i] = (pkts_left[i] > 0) && !hold[i];
      td[i] = base[i] + DW'(seq_cnt[i]);
      tl[i] = (beat_idx[i] == pkt_len[i] - 1);
    end
  endtask

  // Return every source to an empty, idle state
  task automatic clearSources();
    for (int i = 0; i < 4; i++) begin
      pkts_left[i]     = 0;
      pkt_len[i]       = 1;
      beat_idx[i]      = 0;
      seq_cnt[i]       = 0;
      base[i]          = '0;
      hold[i]          = 1'b0;
      hold_after_hs[i] = 1'b0;
      drop_after_hs[i] = 1'b0;
    end
    driveSources();
  endtask

  // Advance n clock cycles: log transfers, update sources after each edge
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      cyc++;
      hs = reset ? 4'b0000 : (tv & tr);
      if (!reset && m_axis_tvalid && m_axis_tready) begin
        obs_tid.push_back(m_axis_tid);
        obs_last.push_back(m_axis_tlast);
        obs_data.push_back(m_axis_tdata);
        obs_cyc.push_back(cyc);
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          seq_cnt[i]++;
          if (beat_idx[i] == pkt_len[i] - 1) begin
            beat_idx[i] = 0;
            pkts_left[i]--;
          end else begin
            beat_idx[i]++;
          end
          if (drop_after_hs[i]) begin
            ch_enable[i]     = 1'b0;
            drop_after_hs[i] = 1'b0;
          end
          if (hold_after_hs[i]) hold[i] = 1'b1;
        end
      end
      if (bp_mode) begin
        m_axis_tready = bp_pat[bp_i % 4];
        bp_i++;
      end
      driveSources();
      #1;
    end
  endtask

  task automatic clearLog();
    obs_tid.delete();
    obs_last.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
    clearLog();
  endtask

  function automatic logic [CW-1:0] packBeat(input logic [1:0] tid, input logic last,
                                             input logic [DW-1:0] data);
    return CW'({tid, last, data});
  endfunction

  // Main directed sequence
  initial begin
    logic [1:0] exp_tid;
    logic [1:0] seq_a [8];
    logic [1:0] seq_b [6];
    int n_out;
    bit any_err;

    checks = 0; errors = 0; cyc = 0;
    bp_mode = 1'b0; bp_i = 0; bp_pat = 4'b1001;
    reset = 1'b1; ch_enable = 4'hF; m_axis_tready = 1'b1;
    clearSources();
    applyStimulus(2);

    // Reset held with every channel requesting
    for (int i = 0; i < 4; i++) begin
      pkts_left[i] = (i == 0) ? 2 : 1;
      pkt_len[i]   = 4;
      base[i]      = DW'(i) << 8;
    end
    driveSources();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("rst_tready%0d", c), CW'(tr), CW'(4'b0000));
      checkOutput($sformatf("rst_mvalid%0d", c), CW'(m_axis_tvalid), CW'(0));
      checkOutput($sformatf("rst_tid%0d", c), CW'(m_axis_tid), CW'(0));
    end
    checkOutput("rst_timeout_err", CW'(timeout_err), CW'(0));
    reset = 1'b0;
    clearLog();
    applyStimulus(1);
    checkOutput("first_grant_ready", CW'(tr), CW'(4'b0001));
    checkOutput("first_grant_mvalid", CW'(m_axis_tvalid), CW'(0));
    applyStimulus(1);
    checkOutput("first_beat", packBeat(m_axis_tid, m_axis_tlast, m_axis_tdata) | CW'(m_axis_tvalid) << (CW-1),
                packBeat(2'd0, 1'b0, '0) | CW'(1) << (CW-1));

    // Fairness: tid 0x4,1x4,2x4,3x4,0x4 with one bubble between packets
    applyStimulus(30);
    checkOutput("fair_count", CW'(obs_tid.size()), CW'(20));
    for (int k = 0; k < 20 && k < obs_tid.size(); k++) begin
      exp_tid = 2'((k / 4) % 4);
      checkOutput($sformatf("fair_beat%0d", k),
                  packBeat(obs_tid[k], obs_last[k], obs_data[k]),
                  packBeat(exp_tid, (k % 4) == 3, (DW'(exp_tid) << 8) + DW'((k / 16) * 4 + k % 4)));
    end
    if (obs_cyc.size() >= 5) begin
      checkOutput("fair_back_to_back", CW'(obs_cyc[1] - obs_cyc[0]), CW'(1));
      checkOutput("fair_packet_gap", CW'(obs_cyc[4] - obs_cyc[3]), CW'(2));
    end

    // Backpressure on ch01: A1..A4 with m_axis_tready 1,0,0,1 repeating
    clearSources();
    resetDut();
    pkts_left[1] = 1; pkt_len[1] = 4; base[1] = DW'(8'hA1);
    driveSources();
    bp_mode = 1'b1; bp_i = 0;
    n_out = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1);
      if (m_axis_tvalid) begin
        checkOutput($sformatf("bp_data%0d", c), CW'(m_axis_tdata), CW'(8'hA1 + n_out));
        checkOutput($sformatf("bp_last%0d", c), CW'(m_axis_tlast), CW'(n_out == 3));
        checkOutput($sformatf("bp_tid%0d", c), CW'(m_axis_tid), CW'(1));
        if (m_axis_tready) n_out++;
      end
    end
    checkOutput("bp_beat_count", CW'(n_out), CW'(4));
    bp_mode = 1'b0; m_axis_tready = 1'b1;

    // Enable gating: only ch01 and ch21 enabled, alternating packets
    clearSources();
    resetDut();
    ch_enable = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      pkts_left[i] = 2; pkt_len[i] = 2; base[i] = DW'(i) << 8;
    end
    driveSources();
    applyStimulus(30);
    seq_a = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3};
    checkOutput("gate_count", CW'(obs_tid.size()), CW'(8));
    for (int k = 0; k < 8 && k < obs_tid.size(); k++)
      checkOutput($sformatf("gate_tid%0d", k), CW'(obs_tid[k]), CW'(seq_a[k]));

    // Enable for ch01 removed after its first beat: packet finishes, no regrant
    clearSources();
    ch_enable = 4'b1010;
    resetDut();
    for (int i = 0; i < 4; i++) begin
      pkts_left[i] = 2; pkt_len[i] = 2; base[i] = DW'(i) << 8;
    end
    drop_after_hs[1] = 1'b1;
    driveSources();
    applyStimulus(30);
    seq_b = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
    checkOutput("drop_count", CW'(obs_tid.size()), CW'(6));
    for (int k = 0; k < 6 && k < obs_tid.size(); k++)
      checkOutput($sformatf("drop_tid%0d", k), CW'(obs_tid[k]), CW'(seq_b[k]));
    checkOutput("drop_ch01_pending", CW'(pkts_left[1]), CW'(1));
    checkOutput("drop_no_ready", CW'(tr), CW'(4'b0000));

    // Reset in the middle of a ch20 packet
    clearSources();
    ch_enable = 4'hF;
    resetDut();
    pkts_left[1] = 1; pkt_len[1] = 2; base[1] = DW'(12'h100);
    pkts_left[2] = 1; pkt_len[2] = 4; base[2] = DW'(12'h200);
    driveSources();
    for (int c = 0; c < 30 && seq_cnt[2] < 2; c++) applyStimulus(1);
    checkOutput("mid_reached_beat2", CW'(seq_cnt[2]), CW'(2));
    checkOutput("mid_slice_beat2", CW'(m_axis_tdata), CW'(12'h201));
    reset = 1'b1;
    pkts_left[0] = 1; pkt_len[0] = 2; base[0] = '0;
    driveSources();
    applyStimulus(1);
    checkOutput("mid_rst_mvalid", CW'(m_axis_tvalid), CW'(0));
    checkOutput("mid_rst_tready", CW'(tr), CW'(4'b0000));
    checkOutput("mid_rst_slice", CW'({m_axis_tid, m_axis_tlast, m_axis_tdata}), CW'(0));
    reset = 1'b0;
    clearLog();
    applyStimulus(14);
    checkOutput("mid_restart_count", CW'(obs_tid.size()), CW'(4));
    if (obs_tid.size() >= 4) begin
      checkOutput("mid_restart_first", packBeat(obs_tid[0], obs_last[0], obs_data[0]),
                  packBeat(2'd0, 1'b0, '0));
      checkOutput("mid_resume_ch20", packBeat(obs_tid[2], obs_last[2], obs_data[2]),
                  packBeat(2'd2, 1'b0, DW'(12'h202)));
      checkOutput("mid_resume_last", packBeat(obs_tid[3], obs_last[3], obs_data[3]),
                  packBeat(2'd2, 1'b1, DW'(12'h203)));
    end

    // ch21 sends one beat without tlast, then goes silent
    clearSources();
    resetDut();
    pkts_left[3] = 1; pkt_len[3] = 4; base[3] = DW'(12'h300);
    hold_after_hs[3] = 1'b1;
    driveSources();
    for (int c = 0; c < 10 && seq_cnt[3] < 1; c++) applyStimulus(1);
    checkOutput("to_first_beat", CW'(seq_cnt[3]), CW'(1));
    pkts_left[0] = 1; pkt_len[0] = 2; base[0] = '0;
    pkts_left[2] = 1; pkt_len[2] = 2; base[2] = DW'(12'h200);
    driveSources();
    #1;
`ifdef AXI_ARB_TIMEOUT_EN
    for (int s = 1; s <= 9; s++) begin
      applyStimulus(1);
      checkOutput($sformatf("to_pulse_s%0d", s), CW'(timeout_err), CW'(s == 8));
    end
    checkOutput("to_regrant_ch00", CW'(tr), CW'(4'b0001));
    applyStimulus(10);
    if (obs_tid.size() >= 2) begin
      checkOutput("to_stranded_beat", packBeat(obs_tid[0], obs_last[0], obs_data[0]),
                  packBeat(2'd3, 1'b0, DW'(12'h300)));
      checkOutput("to_next_tid", CW'(obs_tid[1]), CW'(0));
    end else begin
      checkOutput("to_log_size", CW'(obs_tid.size()), CW'(2));
    end
`else
    any_err = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      applyStimulus(1);
      any_err = any_err | timeout_err;
    end
    checkOutput("hold_no_pulse", CW'(any_err), CW'(0));
    checkOutput("hold_grant_ch21", CW'(tr), CW'(4'b1000));
    checkOutput("hold_single_beat", CW'(obs_tid.size()), CW'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
